// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider for DIV/DIVU: one quotient bit per cycle,
// quotient to LO, remainder to HI, cancellable through annul.
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic        busy,
  output logic        ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  state_nx_s;
  logic [31:0] prem_r;
  logic [31:0] qmag_r;
  logic [31:0] dmag_r;
  logic [31:0] dvd_raw_r;
  logic [4:0]  cnt_r;
  logic        last_r;
  logic        zero_r;
  logic        qneg_r;
  logic        rneg_r;

  logic [32:0] shift_s;
  logic [32:0] diff_s;
  logic [31:0] prem_nx_s;
  logic        qbit_s;
  logic [31:0] dvd_mag_s;
  logic [31:0] dsr_mag_s;

  // Next-state decode; annul overrides every transition.
  always_comb begin
    state_nx_s = state_r;
    if (annul) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nx_s = start ? ST_CALC : ST_IDLE;
        ST_CALC: state_nx_s = last_r ? ST_DONE : ST_CALC;
        ST_DONE: state_nx_s = ST_IDLE;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Operand magnitudes and one restoring shift-subtract step.
  // The partial remainder stays below the divisor, so 32 stored bits suffice;
  // the trial subtraction runs at 33 bits to see the borrow.
  always_comb begin
    dvd_mag_s = dividend;
    dsr_mag_s = divisor;
    if (signed_div && dividend[31]) begin
      dvd_mag_s = 32'd0 - dividend;
    end else begin
      dvd_mag_s = dividend;
    end
    if (signed_div && divisor[31]) begin
      dsr_mag_s = 32'd0 - divisor;
    end else begin
      dsr_mag_s = divisor;
    end
    shift_s = {prem_r, qmag_r[31]};
    diff_s  = shift_s - {1'b0, dmag_r};
    if (diff_s[32]) begin
      prem_nx_s = shift_s[31:0];
      qbit_s    = 1'b0;
    end else begin
      prem_nx_s = diff_s[31:0];
      qbit_s    = 1'b1;
    end
  end

  // State, datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      busy        <= 1'b0;
      ready       <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
      prem_r      <= 32'd0;
      qmag_r      <= 32'd0;
      dmag_r      <= 32'd0;
      dvd_raw_r   <= 32'd0;
      cnt_r       <= 5'd0;
      last_r      <= 1'b0;
      zero_r      <= 1'b0;
      qneg_r      <= 1'b0;
      rneg_r      <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_nx_s != ST_IDLE);
      ready   <= (state_nx_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start && !annul) begin
            zero_r    <= (divisor == 32'd0);
            qmag_r    <= dvd_mag_s;
            dmag_r    <= dsr_mag_s;
            dvd_raw_r <= dividend;
            qneg_r    <= signed_div & (dividend[31] ^ divisor[31]);
            rneg_r    <= signed_div & dividend[31];
            prem_r    <= 32'd0;
            cnt_r     <= 5'd0;
            last_r    <= 1'b0;
          end
        end
        ST_CALC: begin
          if (!annul) begin
            if (!last_r) begin
              prem_r <= prem_nx_s;
              qmag_r <= {qmag_r[30:0], qbit_s};
              cnt_r  <= cnt_r + 5'd1;
              last_r <= (cnt_r == 5'd31);
            end else begin
              // A zero divisor reports the raw dividend, never sign-corrected.
              if (zero_r) begin
                quotient  <= 32'hFFFF_FFFF;
                remainder <= dvd_raw_r;
              end else begin
                quotient  <= qneg_r ? (32'd0 - qmag_r) : qmag_r;
                remainder <= rneg_r ? (32'd0 - prem_r) : prem_r;
              end
              div_by_zero <= zero_r;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus random operands
// checked against a plain-arithmetic reference model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy;
  logic        ready;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks = 0;
  int failures = 0;

  logic [31:0] last_q = 32'd0;
  logic [31:0] last_r = 32'd0;
  logic        last_dz = 1'b0;

  div_iter dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
    .dividend(dividend), .divisor(divisor), .annul(annul),
    .busy(busy), .ready(ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics from 64-bit integer arithmetic.
  task automatic ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      sa = sg ? {{32{a[31]}}, a} : {32'd0, a};
      sb = sg ? {{32{b[31]}}, b} : {32'd0, b};
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      dz = 1'b0;
    end
  endtask

  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    int          lat;
    ref_div(sg, a, b, eq, er, edz);
    @(negedge clk);
    signed_div = sg; dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; signed_div = ~sg; dividend = $urandom; divisor = $urandom;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
    @(negedge clk);
    chk({tag, "_ready_fall"}, 32'(ready), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_q_hold"}, quotient, eq);
    chk({tag, "_r_hold"}, remainder, er);
    last_q = eq; last_r = er; last_dz = edz;
  endtask

  initial begin
    int seen;
    logic sg;
    logic [31:0] a;
    logic [31:0] b;

    // reset state
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    resetn = 1'b1;

    // directed sign, overflow and zero-divisor cases
    run_op(1'b0, 32'd100, 32'd7, "divu_100_7");
    chk("divu_100_7_q_const", last_q, 32'd14);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    chk("div_m7_2_q_const", last_q, 32'hFFFF_FFFD);
    chk("div_m7_2_r_const", last_r, 32'hFFFF_FFFF);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    chk("div_7_m2_r_const", last_r, 32'd1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf_q_const", last_q, 32'h8000_0000);
    run_op(1'b0, 32'd5, 32'd0, "divu_5_0");
    chk("divu_5_0_r_const", last_r, 32'd5);
    run_op(1'b1, 32'hFFFF_FFF0, 32'd0, "div_m16_0");
    run_op(1'b0, 32'd9, 32'd3, "divu_9_3");

    // annul 10 cycles into CALC: no ready, outputs unchanged
    @(negedge clk);
    signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    chk("annul_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) seen++;
    end
    chk("annul_no_ready", 32'(seen), 32'd0);
    chk("annul_q_keep", quotient, last_q);
    chk("annul_r_keep", remainder, last_r);
    chk("annul_dz_keep", 32'(div_by_zero), 32'(last_dz));

    // start while busy (mid-CALC and in DONE) is ignored
    @(negedge clk);
    signed_div = 1'b0; dividend = 32'd77; divisor = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen++;
    end
    dividend = 32'd8; divisor = 32'd2; start = 1'b1;
    @(negedge clk);
    seen++;
    start = 1'b0;
    while (!ready && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    chk("ign_latency", 32'(seen), 32'd33);
    chk("ign_q", quotient, 32'd7);
    chk("ign_r", remainder, 32'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ign_done_busy2", 32'(busy), 32'd0);
    chk("ign_done_q", quotient, 32'd7);

    // start together with annul in IDLE stays idle
    start = 1'b1; annul = 1'b1;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("sa_busy2", 32'(busy), 32'd0);
    chk("sa_ready", 32'(ready), 32'd0);
    last_q = 32'd7; last_r = 32'd7; last_dz = 1'b0;

    // random operands against the reference model
    for (int i = 0; i < 30; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'd0 - 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 200));
      run_op(sg, a, b, "rand");
    end

    // reset mid-CALC clears everything; a new op then completes
    @(negedge clk);
    signed_div = 1'b0; dividend = 32'd123; divisor = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(ready), 32'd0);
    chk("mrst_q", quotient, 32'd0);
    chk("mrst_r", remainder, 32'd0);
    chk("mrst_dz", 32'(div_by_zero), 32'd0);
    resetn = 1'b1;
    run_op(1'b0, 32'd50, 32'd5, "divu_50_5");
    chk("divu_50_5_q_const", last_q, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
